// File: rtl/booth_pkg.sv
// booth_pkg: shared widths, accumulator state enum and saturation limits for the Booth MAC datapath
package booth_pkg;
  localparam int PROD_W = 8;
  localparam int ACC_W = 10;
  localparam int LEN_W = 4;
  typedef enum logic {ACCUM, HOLD} state_t;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
endpackage

// File: rtl/booth_sat_add.sv
// booth_sat_add: combinational signed saturating add; a=accumulator, b=product, y=clamped sum, ovf=clamp occurred
module booth_sat_add
  import booth_pkg::*;
(
  input  logic signed [ACC_W-1:0]  a,
  input  logic signed [PROD_W-1:0] b,
  output logic signed [ACC_W-1:0]  y,
  output logic                     ovf
);
  logic signed [ACC_W:0] s;
  assign s = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){b[PROD_W-1]}}, b};
  assign ovf = s[ACC_W] ^ s[ACC_W-1];
  assign y = ovf ? (s[ACC_W] ? SAT_MIN : SAT_MAX) : s[ACC_W-1:0];
endmodule

// File: rtl/booth_mac_acc.sv
// booth_mac_acc: frame accumulator; prod_in/prod_valid/prod_ready in, sum_out/sat/sum_valid/sum_ready out, len frame size, clear abort
module booth_mac_acc
  import booth_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [LEN_W-1:0]         len,
  input  logic signed [PROD_W-1:0] prod_in,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  output logic signed [ACC_W-1:0]  sum_out,
  output logic                     sat,
  output logic                     sum_valid,
  input  logic                     sum_ready
);
  state_t state, state_nx;
  logic signed [ACC_W-1:0] acc, add_res;
  logic [LEN_W:0] cnt, frame_len, len_ext, eff_len;
  logic sat_flag, ovf, p_acc, s_acc, last;
  booth_sat_add u_add (.a(acc), .b(prod_in), .y(add_res), .ovf(ovf));
  assign prod_ready = state == ACCUM;
  assign sum_valid = state == HOLD;
  assign p_acc = prod_valid & prod_ready;
  assign s_acc = sum_valid & sum_ready;
  assign len_ext = len == '0 ? (LEN_W+1)'(1 << LEN_W) : {1'b0, len};
  assign eff_len = cnt == '0 ? len_ext : frame_len;
  assign last = p_acc && (cnt + 1'b1 == eff_len);
  assign sum_out = acc;
  assign sat = sat_flag;
  always_comb begin
    state_nx = state;
    state_nx = clear ? ACCUM : last ? HOLD : s_acc ? ACCUM : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACCUM;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      sat_flag <= 1'b0;
      frame_len <= '0;
    end else if (clear || s_acc) begin
      acc <= '0;
      cnt <= '0;
      sat_flag <= 1'b0;
    end else if (p_acc) begin
      acc <= add_res;
      cnt <= cnt + 1'b1;
      sat_flag <= sat_flag | ovf;
      if (cnt == '0) frame_len <= len_ext;
    end
endmodule

// File: tb/tb_booth_mac_acc.sv
// tb_booth_mac_acc: directed and random frames checked against an integer saturating-sum model
module tb_booth_mac_acc;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, prod_valid = 1'b0, sum_ready = 1'b1;
  logic [3:0] len = '0;
  logic signed [7:0] prod_in = '0;
  logic prod_ready, sat, sum_valid;
  logic signed [9:0] sum_out;
  int passed = 0, total = 0;
  int q[$];
  booth_mac_acc dut (.clk(clk), .rst_n(rst_n), .clear(clear), .len(len), .prod_in(prod_in),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .sum_out(sum_out), .sat(sat),
    .sum_valid(sum_valid), .sum_ready(sum_ready));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic model(output int s, output int f);
    s = 0;
    f = 0;
    foreach (q[i]) begin
      s += q[i];
      if (s > 511) begin s = 511; f = 1; end
      if (s < -512) begin s = -512; f = 1; end
    end
  endtask
  task automatic run_frame(input int l, input int stall);
    int s, f;
    logic signed [9:0] held;
    model(s, f);
    len = 4'(l);
    foreach (q[i]) begin
      prod_valid = 1'b1;
      prod_in = 8'(q[i]);
      check("prod_ready_accum", prod_ready, 1);
      check("sum_valid_accum", sum_valid, 0);
      cyc();
      len = 4'($urandom);
    end
    prod_valid = 1'b0;
    check("sum_valid_rise", sum_valid, 1);
    check("prod_ready_hold", prod_ready, 0);
    check("sum_out", sum_out, s);
    check("sat", sat, f);
    held = sum_out;
    for (int d = 0; d < stall; d++) begin
      sum_ready = 1'b0;
      prod_valid = 1'b1;
      prod_in = 8'($urandom);
      cyc();
      check("stall_sum_stable", sum_out, held);
      check("stall_sat_stable", sat, f);
      check("stall_prod_ready", prod_ready, 0);
      check("stall_sum_valid", sum_valid, 1);
    end
    prod_valid = 1'b0;
    sum_ready = 1'b1;
    cyc();
    check("sum_valid_drop", sum_valid, 0);
    check("prod_ready_back", prod_ready, 1);
  endtask
  initial begin
    #1;
    check("rst_prod_ready", prod_ready, 1);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_sum_out", sum_out, 0);
    check("rst_sat", sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    q = '{5, -2, 7};
    run_frame(3, 0);
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(64);
    run_frame(16, 0);
    q = '{-128, -128};
    run_frame(2, 0);
    q = '{-128, -128, -128, -128};
    run_frame(4, 0);
    q = '{-128, -128, -128, -128, -1};
    run_frame(5, 0);
    q = '{100, -50, 33};
    run_frame(3, 5);
    len = 4'd4;
    prod_valid = 1'b1;
    prod_in = 8'sd3;
    cyc();
    prod_in = 8'sd4;
    cyc();
    clear = 1'b1;
    prod_in = 8'sd9;
    cyc();
    clear = 1'b0;
    prod_valid = 1'b0;
    check("clear_prod_ready", prod_ready, 1);
    check("clear_sum_valid", sum_valid, 0);
    q = '{1, 1};
    run_frame(2, 0);
    len = 4'd1;
    prod_valid = 1'b1;
    prod_in = 8'sd50;
    cyc();
    prod_valid = 1'b0;
    check("hold_before_clear", sum_valid, 1);
    sum_ready = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    sum_ready = 1'b1;
    check("clear_hold_drop", sum_valid, 0);
    check("clear_hold_ready", prod_ready, 1);
    q = '{3};
    run_frame(1, 0);
    len = 4'd4;
    prod_valid = 1'b1;
    prod_in = 8'sd10;
    cyc();
    prod_in = 8'sd20;
    cyc();
    prod_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum_out", sum_out, 0);
    check("async_rst_sat", sat, 0);
    check("async_rst_prod_ready", prod_ready, 1);
    check("async_rst_sum_valid", sum_valid, 0);
    #1;
    rst_n = 1'b1;
    cyc();
    q = '{7, 8};
    run_frame(2, 0);
    for (int n = 0; n < 25; n++) begin
      int l;
      l = int'($urandom_range(1, 16));
      q = {};
      for (int i = 0; i < l; i++) q.push_back(int'($urandom_range(0, 255)) - 128);
      run_frame(l, int'($urandom_range(0, 2)));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/booth_mac_acc.md
# booth_mac_acc

Signed accumulate stage that sits directly downstream of the 4x4 Booth multiplier. It consumes a stream of 8-bit two's-complement products over a valid/ready handshake and sums a programmable number of them (a frame) into a saturating accumulator. It then presents the frame sum with a sticky saturation flag on an output valid/ready handshake. Together with the multiplier it forms the team's dot-product/MAC datapath.

## Interface
- PROD_W, 8, product width (signed), matches multiplier output
- ACC_W, 10, accumulator and sum width (signed), must be >= PROD_W
- LEN_W, 4, frame-length field width; frame length 1..2^LEN_W
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset
- clear  input  1  synchronous frame abort; highest priority after reset
- len  input  LEN_W  products per frame; value 0 means 2^LEN_W (16)
- prod_in  input  PROD_W  signed product from multiplier
- prod_valid  input  1  prod_in valid
- prod_ready  output  1  stage can accept a product
- sum_out  output  ACC_W  signed frame sum, saturated
- sat  output  1  at least one saturation event occurred in this frame
- sum_valid  output  1  sum_out/sat valid
- sum_ready  input  1  downstream accepts sum

## Operation
- Two states: ACCUM (prod_ready=1, sum_valid=0) and HOLD (prod_ready=0, sum_valid=1).
- Product accept = prod_valid & prod_ready. Sum accept = sum_valid & sum_ready.
- On accept with cnt==0: latch len into frame_len (0 -> 2^LEN_W). len is ignored at all other times.
- On every accept: acc <= sat_add(acc, sext(prod_in)). cnt <= cnt+1. sat_flag |= overflow of that add.
- sat_add: full-precision sum at ACC_W+1 bits; clamp to +2^(ACC_W-1)-1 / -2^(ACC_W-1) on overflow. Saturation is per step and not reversible, so later adds start from the clamped value.
- Accept that makes cnt == frame_len: the next state is HOLD. sum_out/sat take the post-add acc/sat_flag values.
- HOLD with sum accept: the next state is ACCUM, with acc=0, cnt=0 and sat_flag=0.
- clear=1: the next state is ACCUM, with acc=0, cnt=0 and sat_flag=0. Any pending sum_valid drops. A product presented in the same cycle is consumed and discarded, because prod_ready stays combinationally tied to the state.
- The internal cnt is LEN_W+1 bits wide so that a frame of 16 is representable.

## Timing
- Reset values: state=ACCUM, prod_ready=1, sum_valid=0, sum_out=0, sat=0, acc=0, cnt=0.
- Throughput: one product per cycle while in ACCUM.
- Latency: sum_valid rises the cycle after the last product is accepted.
- HOLD adds at least 1 dead cycle per frame, with prod_ready=0. Back-to-back frames therefore cost frame_len+1 cycles.
- sum_out and sat are registered and held stable while sum_valid=1 && sum_ready=0.
- prod_ready and sum_valid are decoded from the state register only. There is no combinational path from sum_ready or prod_valid to either of them.
- A reset assertion mid-frame takes effect immediately, and the partial sum is lost.

## Structure
- Shared package booth_pkg holds:
  - PROD_W, ACC_W, LEN_W defaults
  - state enum {ACCUM, HOLD}
  - SAT_MAX/SAT_MIN constants derived from ACC_W
- One sub-module, booth_sat_add: combinational signed saturating adder.
  - Inputs: ACC_W accumulator and PROD_W addend.
  - Outputs: ACC_W result and an overflow bit.
- Top level holds the FSM, counter and registers.

## Test plan
- Reset, then len=3 and products 5, -2, 7 on consecutive cycles with sum_ready=1.
  - sum_valid pulses 1 cycle after the 3rd accept.
  - sum_out=10, sat=0.
  - prod_ready is low for exactly 1 cycle.
- len=0 with 16 products of 64:
  - acc clamps at the 8th product (512 -> 511) and stays there.
  - sum_out=511, sat=1.
- len=2 with products -128, -128, then -128, -128, -128, -128 across two frames:
  - first sum=-256, sat=0.
  - second frame, len=4: sum=-512, sat=0.
  - a further -1 in a len=5 frame gives -512, sat=1.
- Backpressure: frame completes with sum_ready=0 for 5 cycles.
  - sum_out stable, prod_ready=0 and products ignored throughout.
  - Release sum_ready: the sum is accepted and prod_ready returns the next cycle.
- clear asserted after 2 of 4 products (values 3, 4).
  - Then a fresh len=2 frame of 1, 1 gives sum_out=2, sat=0.
  - clear asserted in HOLD drops sum_valid the next cycle.
- rst_n pulsed low asynchronously mid-frame, between clock edges:
  - outputs reach their reset values without waiting for a clock edge.
  - the next frame sums from zero.
